// File: rtl/rtype_chk_pkg.sv
// Shared definitions for the R-type shadow checker.
//
// Contents:
//   OPC_RTYPE          - RV32I OP major opcode
//   F7_* / F3_*        - funct7 / funct3 encodings of the checked R-type group
//   alu_op_e           - operation selector driven into rtype_alu
//   wb_entry_t         - expected-writeback queue entry {rd, data}
//   rtype_dec_t        - decoder result {legal, op}
//   decode_rtype()     - maps funct7/funct3 onto an ALU op, flags illegal forms
package rtype_chk_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    typedef struct packed {
        logic    legal;
        alu_op_e op;
    } rtype_dec_t;

    // sub_en opens the funct7=0100000 forms (SUB, SRA); every other
    // funct7 / funct3 pairing outside the base group is illegal.
    function automatic rtype_dec_t decode_rtype(input logic [6:0] f7,
                                                input logic [2:0] f3,
                                                input logic       sub_en);
        rtype_dec_t d;
        d.legal = 1'b0;
        d.op    = ALU_ADD;
        if (f7 == F7_BASE) begin
            d.legal = 1'b1;
            case (f3)
                F3_ADD_SUB: d.op = ALU_ADD;
                F3_SLL:     d.op = ALU_SLL;
                F3_SLT:     d.op = ALU_SLT;
                F3_SLTU:    d.op = ALU_SLTU;
                F3_XOR:     d.op = ALU_XOR;
                F3_SRL_SRA: d.op = ALU_SRL;
                F3_OR:      d.op = ALU_OR;
                F3_AND:     d.op = ALU_AND;
            endcase
        end else if (sub_en && f7 == F7_ALT) begin
            if (f3 == F3_ADD_SUB) begin
                d.legal = 1'b1;
                d.op    = ALU_SUB;
            end else if (f3 == F3_SRL_SRA) begin
                d.legal = 1'b1;
                d.op    = ALU_SRA;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/rtype_shadow_checker_alu.sv
// rtype_alu: combinational R-type result computation.
//
// Ports:
//   op     - alu_op_e operation selector
//   a, b   - rs1 / rs2 operand values
//   result - 32-bit wrap-around result; shifts use b[4:0]
module rtype_alu
    import rtype_chk_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic        [4:0]  shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {31'b0, a_s < b_s};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = a_s >>> shamt;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/rtype_shadow_checker.sv
// rtype_shadow_checker: re-executes the R-type instruction stream on a
// private shadow register file and checks the core's writebacks against
// the queued expected results, in order.
//
// Optional feature: define RTYPE_CHK_SUB_EN to also accept SUB and SRA.
//
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   instr_valid, instr               - fetched instruction stream
//   init_we, init_addr, init_data    - shadow register file preload
//   wb_valid, wb_rd, wb_data         - core register writeback
//   mismatch_pulse                   - one cycle after a differing compare
//   mismatch_sticky, overflow_sticky,
//   unexpected_wb_sticky             - latched error flags
//   check_cnt, illegal_cnt           - saturating event counters
//   fifo_count                       - expected-queue occupancy
module rtype_shadow_checker
    import rtype_chk_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          instr_valid,
    input  logic [31:0]                   instr,
    input  logic                          init_we,
    input  logic [4:0]                    init_addr,
    input  logic [31:0]                   init_data,
    input  logic                          wb_valid,
    input  logic [4:0]                    wb_rd,
    input  logic [31:0]                   wb_data,
    output logic                          mismatch_pulse,
    output logic                          mismatch_sticky,
    output logic                          overflow_sticky,
    output logic                          unexpected_wb_sticky,
    output logic [CNT_W-1:0]              check_cnt,
    output logic [CNT_W-1:0]              illegal_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

`ifdef RTYPE_CHK_SUB_EN
    localparam logic SUB_EN = 1'b1;
`else
    localparam logic SUB_EN = 1'b0;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [31:0]   shadow [32];
    wb_entry_t     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Stage p0: decode, operand read and execute, all in the fetch cycle
    logic [6:0]  funct7_p0;
    logic [4:0]  rs2_p0;
    logic [4:0]  rs1_p0;
    logic [2:0]  funct3_p0;
    logic [4:0]  rd_p0;
    logic [6:0]  opcode_p0;
    rtype_dec_t  dec_p0;
    logic [31:0] a_p0;
    logic [31:0] b_p0;
    logic [31:0] result_p0;
    logic        is_rtype_p0;
    logic        accept_p0;
    logic        illegal_p0;
    logic        enq_p0;

    assign {funct7_p0, rs2_p0, rs1_p0, funct3_p0, rd_p0, opcode_p0} = instr;

    assign dec_p0      = decode_rtype(funct7_p0, funct3_p0, SUB_EN);
    assign is_rtype_p0 = instr_valid && !reset && (opcode_p0 == OPC_RTYPE);
    assign accept_p0   = is_rtype_p0 && dec_p0.legal;
    assign illegal_p0  = is_rtype_p0 && !dec_p0.legal;
    assign enq_p0      = accept_p0 && (rd_p0 != 5'd0);

    // x0 is never written, so forcing the read to zero keeps it hardwired.
    assign a_p0 = (rs1_p0 == 5'd0) ? 32'd0 : shadow[rs1_p0];
    assign b_p0 = (rs2_p0 == 5'd0) ? 32'd0 : shadow[rs2_p0];

    rtype_alu u_alu (
        .op     (dec_p0.op),
        .a      (a_p0),
        .b      (b_p0),
        .result (result_p0)
    );

    logic        wb_active;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push;
    logic        differ;
    wb_entry_t   head;

    assign wb_active = wb_valid && !reset && (wb_rd != 5'd0);
    assign empty     = (fifo_count == '0);
    assign full      = (fifo_count == DEPTH_C);
    assign pop       = wb_active && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign push      = enq_p0 && (!full || pop);
    assign head      = fifo_mem[rd_ptr];
    assign differ    = (head != {wb_rd, wb_data});

    // Later assignment wins, so a preload beats an R-type write to the
    // same register; writes to different registers both land.
    always_ff @(posedge clk) begin
        if (enq_p0)
            shadow[rd_p0] <= result_p0;
        if (init_we && init_addr != 5'd0)
            shadow[init_addr] <= init_data;
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{rd: rd_p0, data: result_p0};
    end

    // Stage p1: registered queue control, flags and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            fifo_count           <= '0;
            check_cnt            <= '0;
            illegal_cnt          <= '0;
            mismatch_pulse       <= 1'b0;
            mismatch_sticky      <= 1'b0;
            overflow_sticky      <= 1'b0;
            unexpected_wb_sticky <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase

            mismatch_pulse <= pop && differ;
            if (pop && differ)
                mismatch_sticky <= 1'b1;
            if (enq_p0 && full && !pop)
                overflow_sticky <= 1'b1;
            if (wb_active && empty)
                unexpected_wb_sticky <= 1'b1;
            if (pop)
                check_cnt <= sat_inc(check_cnt);
            if (illegal_p0)
                illegal_cnt <= sat_inc(illegal_cnt);
        end
    end

endmodule

// File: tb/tb_rtype_shadow_checker.sv
// Directed, table-driven bench for rtype_shadow_checker. Counters are
// built 4 bits wide so that saturation is reachable in a short run.
// Build with RTYPE_CHK_SUB_EN defined to exercise the SUB/SRA forms.
module tb_rtype_shadow_checker;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          instr_valid;
    logic [31:0]   instr;
    logic          init_we;
    logic [4:0]    init_addr;
    logic [31:0]   init_data;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          mismatch_pulse;
    logic          mismatch_sticky;
    logic          overflow_sticky;
    logic          unexpected_wb_sticky;
    logic [CW-1:0] check_cnt;
    logic [CW-1:0] illegal_cnt;
    logic [3:0]    fifo_count;

    int checks   = 0;
    int failures = 0;
    int exp_chk  = 0;
    int exp_ill  = 0;

    rtype_shadow_checker #(.FIFO_DEPTH(8), .CNT_W(CW)) dut (
        .clk                  (clk),
        .reset                (reset),
        .instr_valid          (instr_valid),
        .instr                (instr),
        .init_we              (init_we),
        .init_addr            (init_addr),
        .init_data            (init_data),
        .wb_valid             (wb_valid),
        .wb_rd                (wb_rd),
        .wb_data              (wb_data),
        .mismatch_pulse       (mismatch_pulse),
        .mismatch_sticky      (mismatch_sticky),
        .overflow_sticky      (overflow_sticky),
        .unexpected_wb_sticky (unexpected_wb_sticky),
        .check_cnt            (check_cnt),
        .illegal_cnt          (illegal_cnt),
        .fifo_count           (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [31:0] rt(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic int sat(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_reg(input logic [4:0] a, input logic [31:0] d);
        init_we = 1'b1; init_addr = a; init_data = d;
        step();
        init_we = 1'b0;
    endtask

    task automatic exec(input logic [31:0] w);
        instr_valid = 1'b1; instr = w;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        wb_valid = 1'b1; wb_rd = rd; wb_data = d;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_chk = 0;
        exp_ill = 0;
    endtask

    initial begin
        vecs[0] = '{3'b000, 32'd5,          32'd7,          32'd12};
        vecs[1] = '{3'b000, 32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[2] = '{3'b001, 32'd1,          32'h21,         32'd2};
        vecs[3] = '{3'b010, 32'h8000_0000,  32'd1,          32'd1};
        vecs[4] = '{3'b011, 32'h8000_0000,  32'd1,          32'd0};
        vecs[5] = '{3'b100, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0};
        vecs[6] = '{3'b101, 32'h8000_0000,  32'd4,          32'h0800_0000};
        vecs[7] = '{3'b110, 32'h12,         32'h21,         32'h33};
        vecs[8] = '{3'b111, 32'hFF00,       32'h0FF0,       32'h0F00};

        reset = 1'b1; instr_valid = 1'b0; instr = '0;
        init_we = 1'b0; init_addr = '0; init_data = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        step(); step();
        chk("rst_fifo", fifo_count, 0);
        chk("rst_chk", check_cnt, 0);
        chk("rst_ill", illegal_cnt, 0);
        chk("rst_pulse", mismatch_pulse, 0);
        chk("rst_sticky", {mismatch_sticky, overflow_sticky, unexpected_wb_sticky}, 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            init_reg(5'd1, vecs[i].a);
            init_reg(5'd2, vecs[i].b);
            exec(rt(7'b0, vecs[i].f3, 5'd3, 5'd1, 5'd2));
            chk($sformatf("vec%0d_enq", i), fifo_count, 1);
            wb(5'd3, vecs[i].exp);
            exp_chk = sat(exp_chk);
            chk($sformatf("vec%0d_pulse", i), mismatch_pulse, 0);
            chk($sformatf("vec%0d_cnt", i), check_cnt, exp_chk);
            chk($sformatf("vec%0d_pop", i), fifo_count, 0);
        end
        chk("table_sticky", mismatch_sticky, 0);

        // Back-to-back dependent instructions
        init_reg(5'd1, 32'h8000_0000);
        init_reg(5'd2, 32'd1);
        instr_valid = 1'b1;
        instr = rt(7'b0, 3'b010, 5'd4, 5'd1, 5'd2); step();
        instr = rt(7'b0, 3'b011, 5'd5, 5'd1, 5'd2); step();
        instr = rt(7'b0, 3'b000, 5'd6, 5'd4, 5'd5); step();
        instr_valid = 1'b0;
        chk("dep_fifo", fifo_count, 3);
        wb(5'd4, 32'd1); chk("dep_slt", mismatch_pulse, 0);
        wb(5'd5, 32'd0); chk("dep_sltu", mismatch_pulse, 0);
        wb(5'd6, 32'd1); chk("dep_add", mismatch_pulse, 0);
        exp_chk = exp_chk + 3;
        chk("dep_cnt", check_cnt, exp_chk);
        chk("dep_sticky", mismatch_sticky, 0);

        // Mismatching writeback
        init_reg(5'd1, 32'd5);
        init_reg(5'd2, 32'd7);
        exec(rt(7'b0, 3'b000, 5'd3, 5'd1, 5'd2));
        wb(5'd3, 32'd13);
        exp_chk = sat(exp_chk);
        chk("mm_pulse", mismatch_pulse, 1);
        chk("mm_sticky", mismatch_sticky, 1);
        chk("mm_cnt", check_cnt, exp_chk);
        step();
        chk("mm_pulse_end", mismatch_pulse, 0);
        chk("mm_sticky_hold", mismatch_sticky, 1);

        // check_cnt saturation
        for (int i = 0; i < 3; i++) begin
            exec(rt(7'b0, 3'b000, 5'd3, 5'd1, 5'd2));
            wb(5'd3, 32'd12);
            exp_chk = sat(exp_chk);
        end
        chk("chk_sat", check_cnt, exp_chk);

        do_reset();
        chk("rst2_sticky", mismatch_sticky, 0);
        chk("rst2_cnt", check_cnt, 0);

        // Unexpected writebacks
        wb(5'd0, 32'd5);
        chk("wb_rd0", unexpected_wb_sticky, 0);
        wb(5'd7, 32'd5);
        chk("wb_unexp", unexpected_wb_sticky, 1);
        chk("wb_unexp_cnt", check_cnt, 0);
        do_reset();

        // Enqueue and writeback together at empty: no pop of the new entry
        instr_valid = 1'b1; instr = rt(7'b0, 3'b000, 5'd3, 5'd1, 5'd2);
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'd12;
        step();
        instr_valid = 1'b0; wb_valid = 1'b0;
        chk("empty_both_fifo", fifo_count, 1);
        chk("empty_both_unexp", unexpected_wb_sticky, 1);
        chk("empty_both_cnt", check_cnt, 0);
        wb(5'd3, 32'd12);
        chk("empty_both_pulse", mismatch_pulse, 0);
        do_reset();

        // Overflow
        instr_valid = 1'b1; instr = rt(7'b0, 3'b000, 5'd3, 5'd1, 5'd2);
        repeat (8) step();
        chk("full_fifo", fifo_count, 8);
        chk("full_ovf", overflow_sticky, 0);
        step();
        instr_valid = 1'b0;
        chk("ovf_fifo", fifo_count, 8);
        chk("ovf_sticky", overflow_sticky, 1);
        do_reset();

        // Enqueue and pop together at full
        instr_valid = 1'b1;
        repeat (8) step();
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'd12;
        step();
        instr_valid = 1'b0; wb_valid = 1'b0;
        exp_chk = sat(exp_chk);
        chk("full_both_fifo", fifo_count, 8);
        chk("full_both_ovf", overflow_sticky, 0);
        chk("full_both_cnt", check_cnt, exp_chk);
        chk("full_both_pulse", mismatch_pulse, 0);
        for (int i = 0; i < 8; i++) begin
            wb(5'd3, 32'd12);
            exp_chk = sat(exp_chk);
        end
        chk("drain_fifo", fifo_count, 0);
        chk("drain_cnt", check_cnt, exp_chk);
        chk("drain_sticky", mismatch_sticky, 0);

        // Preload beats an R-type write to the same register
        init_we = 1'b1; init_addr = 5'd3; init_data = 32'h0000_AAAA;
        instr_valid = 1'b1; instr = rt(7'b0, 3'b000, 5'd3, 5'd1, 5'd2);
        step();
        init_we = 1'b0; instr_valid = 1'b0;
        exec(rt(7'b0, 3'b000, 5'd7, 5'd3, 5'd0));
        wb(5'd3, 32'd12);
        chk("prio_q", mismatch_pulse, 0);
        wb(5'd7, 32'h0000_AAAA);
        chk("prio_val", mismatch_pulse, 0);

        // rd = 0 neither enqueues nor becomes readable
        exec(rt(7'b0, 3'b000, 5'd0, 5'd1, 5'd2));
        chk("rd0_fifo", fifo_count, 0);
        exec(rt(7'b0, 3'b000, 5'd8, 5'd0, 5'd1));
        wb(5'd8, 32'd5);
        chk("x0_zero", mismatch_pulse, 0);
        chk("x0_sticky", mismatch_sticky, 0);
        do_reset();

        // Illegal / ignored instructions
        exec(32'h0000_0013);
        chk("nop_ill", illegal_cnt, 0);
        chk("nop_fifo", fifo_count, 0);
        exec(32'h4020_8033);
`ifndef RTYPE_CHK_SUB_EN
        exp_ill = sat(exp_ill);
`endif
        chk("sub_x0_ill", illegal_cnt, exp_ill);
        chk("sub_x0_fifo", fifo_count, 0);
        exec(rt(7'b0000001, 3'b000, 5'd3, 5'd1, 5'd2));
        exp_ill = sat(exp_ill);
        chk("f7_bad_ill", illegal_cnt, exp_ill);
        chk("f7_bad_fifo", fifo_count, 0);
        exec(rt(7'b0100000, 3'b001, 5'd3, 5'd1, 5'd2));
        exp_ill = sat(exp_ill);
        chk("alt_sll_ill", illegal_cnt, exp_ill);
`ifdef RTYPE_CHK_SUB_EN
        exec(rt(7'b0100000, 3'b000, 5'd3, 5'd1, 5'd2));
        chk("sub_fifo", fifo_count, 1);
        wb(5'd3, 32'hFFFF_FFFE);
        chk("sub_pulse", mismatch_pulse, 0);
        init_reg(5'd1, 32'h8000_0000);
        init_reg(5'd2, 32'd4);
        exec(rt(7'b0100000, 3'b101, 5'd3, 5'd1, 5'd2));
        wb(5'd3, 32'hF800_0000);
        chk("sra_pulse", mismatch_pulse, 0);
        chk("sub_ill", illegal_cnt, exp_ill);
`endif
        for (int i = 0; i < 20; i++) begin
            exec(rt(7'b0000001, 3'b000, 5'd3, 5'd1, 5'd2));
            exp_ill = sat(exp_ill);
        end
        chk("ill_sat", illegal_cnt, exp_ill);
        do_reset();

        // Reset with entries in flight; shadow contents survive
        init_reg(5'd1, 32'd5);
        init_reg(5'd2, 32'd7);
        instr_valid = 1'b1;
        instr = rt(7'b0, 3'b000, 5'd8,  5'd1, 5'd2); step();
        instr = rt(7'b0, 3'b000, 5'd9,  5'd1, 5'd2); step();
        instr = rt(7'b0, 3'b000, 5'd10, 5'd1, 5'd2); step();
        chk("pre_rst_fifo", fifo_count, 3);
        reset = 1'b1;
        instr = rt(7'b0, 3'b000, 5'd12, 5'd1, 5'd2);
        wb_valid = 1'b1; wb_rd = 5'd8; wb_data = 32'd12;
        step();
        reset = 1'b0; instr_valid = 1'b0; wb_valid = 1'b0;
        exp_chk = 0;
        chk("mid_rst_fifo", fifo_count, 0);
        chk("mid_rst_cnt", check_cnt, 0);
        chk("mid_rst_unexp", unexpected_wb_sticky, 0);
        exec(rt(7'b0, 3'b000, 5'd11, 5'd8, 5'd1));
        wb(5'd11, 32'd17);
        chk("shadow_kept", mismatch_pulse, 0);
        chk("shadow_kept_cnt", check_cnt, 1);
        chk("shadow_kept_fifo", fifo_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
